ps2_keycode_receiver: RTL
=========================

# ps2_keycode_receiver

Receives the PS/2 keyboard serial stream (ps2_clk / ps2_data from the board pins), deframes 11-bit PS/2 frames and presents the last two received scan-code bytes as a 16-bit keycode. It sits directly upstream of the keycode decoder: {previous byte, latest byte} feeds the decoder's keycode input, so a break sequence F0 xx appears as 16'hF0xx. It also provides synchronisation, glitch filtering, parity/stop checking and a stalled-frame timeout.

## Interface
Parameters:
- FILTER_LEN, 4: consecutive identical synchronised ps2_clk samples required before the filtered clock changes level (≥1).
- TIMEOUT_CYCLES, 100_000: clk cycles without a filtered ps2_clk falling edge before an open frame is aborted.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst = 0 resets).
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous, idle high.
- ps2_data  input  1  raw PS/2 data from pin, asynchronous, idle high.
- keycode  output  16  {previous byte, latest byte}; holds until the next valid frame.
- keycode_valid  output  1  one-cycle pulse in the cycle keycode takes a new value.
- frame_err  output  1  one-cycle pulse on a rejected or aborted frame.

## Operation
- Both pins pass through 2-flop synchronisers (reset value 1).
- Filter on synchronised ps2_clk: a counter counts cycles in which the sample differs from the filtered level and clears whenever they match. At FILTER_LEN the filtered level toggles and the counter clears. Filtered level resets to 1.
- Falling edge event: filtered level was 1 in the previous cycle and is 0 now. The synchronised ps2_data is sampled only on these events.
- FSM states: IDLE, DATA, PARITY, STOP. Reset state is IDLE.
  - IDLE: an edge event with data = 0 (start bit) clears the shift register, bit counter and timeout counter, then moves to DATA. An edge event with data = 1 is ignored.
  - DATA: each edge event shifts data in LSB-first. A 3-bit counter tracks bits; after the 8th bit the FSM moves to PARITY.
  - PARITY: stores the sampled bit and moves to STOP.
  - STOP: on the edge event, the frame is accepted if parity is odd (XOR of 8 data bits and the parity bit = 1) and the stop bit = 1. Either way the FSM returns to IDLE.
- Accepted frame: keycode <= {keycode[7:0], byte}; keycode_valid = 1 for that one cycle.
- Rejected frame: keycode unchanged; frame_err = 1 for one cycle.
- Timeout: in DATA, PARITY or STOP, the counter increments every cycle and clears on each edge event. When it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE, partial data is discarded and frame_err pulses. Counter width is $clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.
- If an edge event and timeout occur in the same cycle, the edge event wins and the counter clears.
- Byte values such as E0, F0 and AA are shifted in like any data; no interpretation is done here.
- Device-to-host only; the block never drives the pins.

## Timing
- Reset values: keycode = 16'h0000, keycode_valid = 0, frame_err = 0, FSM = IDLE, counters = 0.
- Asynchronous reset mid-frame discards the partial frame immediately. After release, the next start bit begins a fresh frame. An in-progress device frame is discarded via a parity, stop or timeout error.
- Edge-event latency: if clk edge k is the first to sample ps2_clk low (stably), the edge event occurs in the cycle after edge k+1+FILTER_LEN.
- Output latency: keycode and keycode_valid update at edge k+2+FILTER_LEN relative to the stop-bit falling edge. frame_err uses the same latency, or the cycle after the timeout is reached.
- keycode_valid and frame_err are registered, never high together, and never high two cycles in a row. The minimum spacing between pulses is one PS/2 frame.
- ps2_clk pulses shorter than FILTER_LEN cycles produce no edge event.

## Test plan
- Reset, pins idle high → keycode = 16'h0000, no pulses for 10,000 cycles.
- Frame for 8'h1C (start 0, LSB-first, parity 0, stop 1) at ~12.5 kHz → keycode = 16'h001C, one keycode_valid pulse at stop-edge + FILTER_LEN + 2 cycles.
- Sequence 1D, F0, 1D → keycode steps 16'h001D, 16'h1DF0, 16'hF01D, with three valid pulses.
- Frame 8'h23 with parity bit flipped, then one with stop = 0 → two frame_err pulses, keycode unchanged, no valid pulse.
- 2-cycle low glitches on ps2_clk while idle and mid-frame (FILTER_LEN = 4) → ignored, and the following good frame decodes correctly.
- Stop clocking after 4 data bits → frame_err after TIMEOUT_CYCLES, FSM in IDLE. A following frame 8'h1C is accepted. Repeat with rst pulsed low mid-frame → outputs 0 immediately, and the next complete frame is accepted.

Source files
------------

// File: rtl/ps2_keycode_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deframes 11-bit frames
// and presents the last two scan-code bytes as {previous, latest}.
module ps2_keycode_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        frame_err
);

  localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt, filt_prev;
  logic [FW-1:0] fcnt;
  logic          fall;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0]   keycode_n;
  logic          valid_n, err_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      data_s1   <= ps2_data;
      data_s2   <= data_s1;
      filt_prev <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        filt <= ~filt;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shift         <= '0;
      bitcnt        <= '0;
      par           <= 1'b0;
      tcnt          <= '0;
      keycode       <= '0;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_n;
      shift         <= shift_n;
      bitcnt        <= bitcnt_n;
      par           <= par_n;
      tcnt          <= tcnt_n;
      keycode       <= keycode_n;
      keycode_valid <= valid_n;
      frame_err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bitcnt_n  = bitcnt;
    par_n     = par;
    tcnt_n    = tcnt;
    keycode_n = keycode;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (state == IDLE) begin
      tcnt_n = '0;
      if (fall && !data_s2) begin
        shift_n  = '0;
        bitcnt_n = '0;
        state_n  = DATA;
      end
    end else if (fall) begin
      // An edge event outranks a coinciding timeout and restarts the stall counter.
      tcnt_n = '0;
      case (state)
        DATA: begin
          shift_n  = {data_s2, shift[7:1]};
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_s2;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          if (((^shift) ^ par) && data_s2) begin
            keycode_n = {keycode[7:0], shift};
            valid_n   = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      endcase
    end else if (tcnt == T_LAST) begin
      state_n = IDLE;
      tcnt_n  = '0;
      err_n   = 1'b1;
    end else if (tcnt != '1) begin
      tcnt_n = tcnt + 1'b1;
    end
  end

endmodule
